// File: rtl/fir_stream_pkg.sv
// Stream types shared between the sample packer and the decimating FIR.
package fir_stream_pkg;

   localparam int DATA_WIDTH    = 16;
   localparam int CHANNELS      = 2;
   localparam int P_SAMPLES     = 8;
   localparam int DEF_OUT_DEPTH = 2;
   localparam int LANE_W        = $clog2(P_SAMPLES);
   localparam int BEAT_DATA_W   = CHANNELS * P_SAMPLES * DATA_WIDTH;

   typedef logic signed [DATA_WIDTH-1:0] lane_t;
   typedef logic [LANE_W-1:0]            lane_idx_t;

   localparam lane_idx_t LAST_LANE = lane_idx_t'(P_SAMPLES - 1);

   // Packed so that {ch1, ch0} is exactly the wide AXI-Stream payload:
   // ch0 lane j at [16*j +: 16], ch1 lane j at [128 + 16*j +: 16].
   typedef struct packed {
      logic                    tlast;
      lane_t [P_SAMPLES-1:0]   ch1;
      lane_t [P_SAMPLES-1:0]   ch0;
   } beat_t;

   typedef enum logic [0:0] {
      COLLECT    = 1'b0,
      FLUSH_WAIT = 1'b1
   } pack_state_e;

   // Payload bits of a beat without the tlast flag.
   function automatic logic [BEAT_DATA_W-1:0] beat_payload(input beat_t b);
      return {b.ch1, b.ch0};
   endfunction

endpackage

// File: rtl/fir_beat_fifo.sv
// Synchronous FIFO of packed beats. Occupancy counter gives full/empty;
// pushes while full and pops while empty are ignored. The head entry is
// read straight from the storage register selected by the read pointer.
module fir_beat_fifo
   import fir_stream_pkg::*;
#(
   parameter int DEPTH = DEF_OUT_DEPTH
) (
   input  logic  clk,
   input  logic  nrst,
   input  logic  push_i,
   input  beat_t push_data_i,
   input  logic  pop_i,
   output beat_t head_o,
   output logic  full_o,
   output logic  empty_o,
   output logic  full_next_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
   localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);

   beat_t mem_q [DEPTH];
   ptr_t  wr_ptr_q, wr_ptr_d;
   ptr_t  rd_ptr_q, rd_ptr_d;
   cnt_t  count_q, count_d;
   logic  do_push, do_pop;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
   endfunction

   assign do_push = push_i && (count_q != CNT_FULL);
   assign do_pop  = pop_i && (count_q != '0);

   // Next pointers and occupancy from this cycle's effective push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + cnt_t'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - cnt_t'(1);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Beat storage; cleared on reset so the head reads as all-zero when idle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o      = mem_q[rd_ptr_q];
   assign full_o      = (count_q == CNT_FULL);
   assign empty_o     = (count_q == '0);
   assign full_next_o = (count_d == CNT_FULL);

endmodule

// File: rtl/fir_sample_packer.sv
// Packs P_SAMPLES consecutive sample pairs into one wide beat for the FIR,
// buffers finished beats in a small FIFO, and closes a partial beat with
// zero padding on flush.
//
// Handshake rule on both sides: a transfer happens on the rising edge where
// valid && ready; the sender holds valid and data stable until that edge,
// and ready never depends combinationally on the other side's signals.
module fir_sample_packer
   import fir_stream_pkg::*;
#(
   parameter int OUT_DEPTH = 2
) (
   input  logic                                   clk,
   input  logic                                   nrst,
   input  logic                                   s_tvalid,
   output logic                                   s_tready,
   input  logic [CHANNELS*DATA_WIDTH-1:0]         s_tdata,
   input  logic                                   flush,
   output logic                                   m_tvalid,
   input  logic                                   m_tready,
   output logic [BEAT_DATA_W-1:0]                 m_tdata,
   output logic                                   m_tlast,
   output logic [31:0]                            beat_count,
   output pack_state_e                            dbg_state_o
);

   pack_state_e state_q, state_d;
   lane_idx_t   lane_q, lane_d;
   beat_t       asm_q, asm_d;
   logic        s_tready_q, s_tready_d;
   logic [31:0] beat_count_q, beat_count_d;

   beat_t beat_with_sample;
   beat_t push_beat;
   beat_t fifo_head;
   logic  accept;
   logic  close_req;
   logic  push;
   logic  pop;
   logic  fifo_full;
   logic  fifo_empty;
   logic  fifo_full_next;

   assign accept    = s_tvalid && s_tready_q;
   assign pop       = !fifo_empty && m_tready;
   // A flush only closes a beat if there is something in it, counting a
   // sample that arrives on the same edge.
   assign close_req = flush && ((lane_q != '0) || accept);

   // Assembly register with this cycle's accepted sample written into its lane.
   always_comb begin
      beat_with_sample = asm_q;
      if (accept) begin
         beat_with_sample.ch0[lane_q] = lane_t'(s_tdata[DATA_WIDTH-1:0]);
         beat_with_sample.ch1[lane_q] = lane_t'(s_tdata[2*DATA_WIDTH-1:DATA_WIDTH]);
      end
   end

   // FSM next state, lane counter, assembly update and FIFO push.
   // The assembly register is cleared after every push, so lanes that were
   // never written are already zero when a partial beat is closed.
   always_comb begin
      state_d         = state_q;
      lane_d          = lane_q;
      asm_d           = asm_q;
      push            = 1'b0;
      push_beat       = beat_with_sample;
      push_beat.tlast = 1'b0;
      case (state_q)
         COLLECT: begin
            asm_d = beat_with_sample;
            if (accept) begin
               lane_d = lane_q + lane_idx_t'(1);
            end
            if (close_req) begin
               if (!fifo_full) begin
                  push            = 1'b1;
                  push_beat.tlast = 1'b1;
                  asm_d           = '0;
                  lane_d          = '0;
               end else begin
                  state_d = FLUSH_WAIT;
               end
            end else if (accept && (lane_q == LAST_LANE)) begin
               push  = 1'b1;
               asm_d = '0;
            end
         end
         FLUSH_WAIT: begin
            if (!fifo_full) begin
               push            = 1'b1;
               push_beat       = asm_q;
               push_beat.tlast = 1'b1;
               asm_d           = '0;
               lane_d          = '0;
               state_d         = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   // Ready for next cycle: only while collecting, and not when the next
   // sample would complete a beat that the FIFO has no room for.
   always_comb begin
      s_tready_d = (state_d == COLLECT) && !((lane_d == LAST_LANE) && fifo_full_next);
   end

   // Count every beat handed to the FIR.
   always_comb begin
      beat_count_d = beat_count_q + {31'd0, pop};
   end

   // Packer state registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= COLLECT;
         lane_q       <= '0;
         asm_q        <= '0;
         s_tready_q   <= 1'b0;
         beat_count_q <= '0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         asm_q        <= asm_d;
         s_tready_q   <= s_tready_d;
         beat_count_q <= beat_count_d;
      end
   end

   fir_beat_fifo #(
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .nrst        (nrst),
      .push_i      (push),
      .push_data_i (push_beat),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .full_next_o (fifo_full_next)
   );

   assign s_tready    = s_tready_q;
   assign m_tvalid    = !fifo_empty;
   assign m_tdata     = beat_payload(fifo_head);
   assign m_tlast     = fifo_head.tlast;
   assign beat_count  = beat_count_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fir_sample_packer.sv
// Directed bench for fir_sample_packer: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge or 1 ns after the rising edge.
module tb_fir_sample_packer;
   import fir_stream_pkg::*;

   localparam int BW = BEAT_DATA_W + 1;

   // ---------------- clock / reset ----------------
   logic clk;
   logic nrst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic                   s_tvalid;
   logic                   s_tready;
   logic [31:0]            s_tdata;
   logic                   flush;
   logic                   m_tvalid;
   logic                   m_tready;
   logic [BEAT_DATA_W-1:0] m_tdata;
   logic                   m_tlast;
   logic [31:0]            beat_count;
   pack_state_e            dbg_state;

   fir_sample_packer #(.OUT_DEPTH(2)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tdata     (s_tdata),
      .flush       (flush),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tdata     (m_tdata),
      .m_tlast     (m_tlast),
      .beat_count  (beat_count),
      .dbg_state_o (dbg_state)
   );

   int n_cmp;
   int n_fail;

   // ---------------- scoreboard ----------------
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] got_q[$];

   // Capture every beat that will transfer on the next rising edge.
   always @(negedge clk) begin
      if (nrst && m_tvalid && m_tready) begin
         got_q.push_back({m_tlast, m_tdata});
      end
   end

   // Expected beat: first n lanes hold base+j per channel, rest zero.
   function automatic logic [BW-1:0] make_beat(input logic [15:0] c0_base,
                                               input logic [15:0] c1_base,
                                               input int n, input logic last);
      logic [BW-1:0] b;
      b = '0;
      for (int j = 0; j < n; j++) begin
         b[16*j +: 16]       = c0_base + 16'(j);
         b[128 + 16*j +: 16] = c1_base + 16'(j);
      end
      b[BW-1] = last;
      return b;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      nrst     = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      flush    = 1'b0;
      m_tready = 1'b0;
      tick(2);
      nrst = 1'b1;
      tick(1);
      exp_q.delete();
      got_q.delete();
   endtask

   // Offer one pair (optionally with flush) and return 1 ns after it is accepted.
   task automatic send(input logic [15:0] c1, input logic [15:0] c0, input logic fl);
      int n;
      s_tvalid = 1'b1;
      s_tdata  = {c1, c0};
      flush    = fl;
      n = 0;
      while (!s_tready && n < 100) begin
         tick(1);
         n++;
      end
      n_cmp++;
      if (!s_tready) begin
         n_fail++;
         $display("FAIL send_timeout s_tready=%0b expected 1 within 100 cycles", s_tready);
      end
      tick(1);
      s_tvalid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
   endtask

   task automatic wait_beats(input int n_beats);
      int n;
      n = 0;
      while (got_q.size() < n_beats && n < 200) begin
         tick(1);
         n++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      nrst     = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      flush    = 1'b0;
      m_tready = 1'b0;
      #1 nrst = 1'b0;
      #2;
      n_cmp++; if (s_tready !== 1'b0)   begin n_fail++; $display("FAIL rst_s_tready got=%b exp=0", s_tready); end
      n_cmp++; if (m_tvalid !== 1'b0)   begin n_fail++; $display("FAIL rst_m_tvalid got=%b exp=0", m_tvalid); end
      n_cmp++; if (m_tdata !== '0)      begin n_fail++; $display("FAIL rst_m_tdata got=%h exp=0", m_tdata); end
      n_cmp++; if (m_tlast !== 1'b0)    begin n_fail++; $display("FAIL rst_m_tlast got=%b exp=0", m_tlast); end
      n_cmp++; if (beat_count !== 32'd0) begin n_fail++; $display("FAIL rst_beat_count got=%0d exp=0", beat_count); end
      tick(2);
      nrst = 1'b1;
      n_cmp++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_release_s_tready got=%b exp=0", s_tready); end
      tick(1);
      n_cmp++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rise got=%b exp=1", s_tready); end
      n_cmp++; if (dbg_state !== COLLECT) begin n_fail++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, COLLECT); end
   endtask

   task automatic test_full_beat();
      logic [BW-1:0] e;
      do_reset();
      m_tready = 1'b1;
      for (int i = 0; i < 7; i++) send(16'h1000 + 16'(i), 16'(i), 1'b0);
      n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL t1_early_valid got=%b exp=0", m_tvalid); end
      send(16'h1007, 16'h0007, 1'b0);
      e = make_beat(16'h0000, 16'h1000, 8, 1'b0);
      n_cmp++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL t1_latency got=%b exp=1", m_tvalid); end
      n_cmp++; if (m_tdata !== e[BEAT_DATA_W-1:0]) begin n_fail++; $display("FAIL t1_data got=%h exp=%h", m_tdata, e[BEAT_DATA_W-1:0]); end
      n_cmp++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL t1_tlast got=%b exp=0", m_tlast); end
      tick(1);
      n_cmp++; if (beat_count !== 32'd1) begin n_fail++; $display("FAIL t1_count got=%0d exp=1", beat_count); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL t1_drained got=%b exp=0", m_tvalid); end
   endtask

   task automatic test_flush_partial();
      logic [BW-1:0] e;
      do_reset();
      m_tready = 1'b1;
      for (int i = 0; i < 3; i++) send(16'hFFF0 + 16'(i), 16'd1 + 16'(i), 1'b0);
      pulse_flush();
      e = make_beat(16'h0001, 16'hFFF0, 3, 1'b1);
      n_cmp++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL t2_valid got=%b exp=1", m_tvalid); end
      n_cmp++; if (m_tdata !== e[BEAT_DATA_W-1:0]) begin n_fail++; $display("FAIL t2_data got=%h exp=%h", m_tdata, e[BEAT_DATA_W-1:0]); end
      n_cmp++; if (m_tlast !== 1'b1) begin n_fail++; $display("FAIL t2_tlast got=%b exp=1", m_tlast); end
      tick(1);
      n_cmp++; if (beat_count !== 32'd1) begin n_fail++; $display("FAIL t2_count got=%0d exp=1", beat_count); end
   endtask

   task automatic test_back_to_back();
      logic [BW-1:0] e, g;
      int k;
      do_reset();
      for (int i = 0; i < 16; i++) send(16'h8000 + 16'(i), 16'h0100 + 16'(i), 1'b0);
      n_cmp++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL t3_ready_lane0 got=%b exp=1", s_tready); end
      for (int i = 16; i < 23; i++) send(16'h8000 + 16'(i), 16'h0100 + 16'(i), 1'b0);
      n_cmp++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL t3_ready_lane7 got=%b exp=0", s_tready); end
      tick(2);
      n_cmp++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL t3_ready_hold got=%b exp=0", s_tready); end
      m_tready = 1'b1;
      send(16'h8017, 16'h0117, 1'b0);
      exp_q.push_back(make_beat(16'h0100, 16'h8000, 8, 1'b0));
      exp_q.push_back(make_beat(16'h0108, 16'h8008, 8, 1'b0));
      exp_q.push_back(make_beat(16'h0110, 16'h8010, 8, 1'b0));
      wait_beats(3);
      tick(3);
      n_cmp++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL t3_beats got=%0d exp=3", got_q.size()); end
      k = 0;
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_fail++; $display("FAIL t3_beat%0d got=%h exp=%h", k, g, e); end
         k++;
      end
      n_cmp++; if (beat_count !== 32'd3) begin n_fail++; $display("FAIL t3_count got=%0d exp=3", beat_count); end
   endtask

   task automatic test_flush_wait();
      logic [BW-1:0] e, g;
      int k;
      do_reset();
      for (int i = 0; i < 21; i++) send(16'h7F00 + 16'(i), 16'h0200 + 16'(i), 1'b0);
      pulse_flush();
      n_cmp++; if (dbg_state !== FLUSH_WAIT) begin n_fail++; $display("FAIL t4_state got=%0d exp=%0d", dbg_state, FLUSH_WAIT); end
      n_cmp++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL t4_ready got=%b exp=0", s_tready); end
      pulse_flush();
      tick(1);
      n_cmp++; if (dbg_state !== FLUSH_WAIT) begin n_fail++; $display("FAIL t4_state_hold got=%0d exp=%0d", dbg_state, FLUSH_WAIT); end
      m_tready = 1'b1;
      tick(1);
      m_tready = 1'b0;
      tick(1);
      n_cmp++; if (dbg_state !== COLLECT) begin n_fail++; $display("FAIL t4_state_back got=%0d exp=%0d", dbg_state, COLLECT); end
      n_cmp++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL t4_ready_back got=%b exp=1", s_tready); end
      exp_q.push_back(make_beat(16'h0200, 16'h7F00, 8, 1'b0));
      exp_q.push_back(make_beat(16'h0208, 16'h7F08, 8, 1'b0));
      exp_q.push_back(make_beat(16'h0210, 16'h7F10, 5, 1'b1));
      m_tready = 1'b1;
      wait_beats(3);
      tick(3);
      n_cmp++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL t4_beats got=%0d exp=3", got_q.size()); end
      k = 0;
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_fail++; $display("FAIL t4_beat%0d got=%h exp=%h", k, g, e); end
         k++;
      end
   endtask

   task automatic test_flush_on_last();
      logic [BW-1:0] e;
      do_reset();
      m_tready = 1'b1;
      for (int i = 0; i < 7; i++) send(16'hC000 + 16'(i), 16'h0400 + 16'(i), 1'b0);
      send(16'hC007, 16'h0407, 1'b1);
      e = make_beat(16'h0400, 16'hC000, 8, 1'b1);
      n_cmp++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL t5_valid got=%b exp=1", m_tvalid); end
      n_cmp++; if ({m_tlast, m_tdata} !== e) begin n_fail++; $display("FAIL t5_beat got=%h exp=%h", {m_tlast, m_tdata}, e); end
      tick(1);
      pulse_flush();
      tick(3);
      n_cmp++; if (beat_count !== 32'd1) begin n_fail++; $display("FAIL t5_count got=%0d exp=1", beat_count); end
      n_cmp++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL t5_no_empty_beat got=%0d exp=1", got_q.size()); end
   endtask

   task automatic test_reset_mid();
      logic [BW-1:0] e;
      do_reset();
      for (int i = 0; i < 18; i++) send(16'h3000 + 16'(i), 16'h0300 + 16'(i), 1'b0);
      n_cmp++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL t6_queued got=%b exp=1", m_tvalid); end
      #2 nrst = 1'b0;
      #1;
      n_cmp++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL t6_s_tready got=%b exp=0", s_tready); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL t6_m_tvalid got=%b exp=0", m_tvalid); end
      n_cmp++; if (m_tdata !== '0) begin n_fail++; $display("FAIL t6_m_tdata got=%h exp=0", m_tdata); end
      tick(2);
      nrst = 1'b1;
      tick(1);
      m_tready = 1'b1;
      for (int i = 0; i < 8; i++) send(16'hA500 + 16'(i), 16'h5A00 + 16'(i), 1'b0);
      tick(1);
      e = make_beat(16'h5A00, 16'hA500, 8, 1'b0);
      n_cmp++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL t6_beats got=%0d exp=1", got_q.size()); end
      if (got_q.size() > 0) begin
         n_cmp++; if (got_q[0] !== e) begin n_fail++; $display("FAIL t6_beat got=%h exp=%h", got_q[0], e); end
      end
      n_cmp++; if (beat_count !== 32'd1) begin n_fail++; $display("FAIL t6_count got=%0d exp=1", beat_count); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_full_beat();
      test_flush_partial();
      test_back_to_back();
      test_flush_wait();
      test_flush_on_last();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
